// File: rtl/lcd_bus_reader.sv
// HD44780-style LCD read engine: status/data single reads and a busy-flag poll loop.
// Generates E/RS/RW timing from one down-counter. It never drives the data bus.
module lcd_bus_reader #(
  parameter int SETUP_CYCLES   = 3,
  parameter int EN_HIGH_CYCLES = 25,
  parameter int HOLD_CYCLES    = 2,
  parameter int GAP_CYCLES     = 25,
  parameter int MAX_POLLS      = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] cmd,
  output logic       busy,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_timeout,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, HOLD, GAP, DONE} state_t;

  localparam int MAX_A   = (SETUP_CYCLES > EN_HIGH_CYCLES) ? SETUP_CYCLES : EN_HIGH_CYCLES;
  localparam int MAX_B   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(EN_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYCLES - 1);
  localparam logic [7:0]    POLL_LIM = 8'(MAX_POLLS);
  localparam logic [1:0]    CMD_STATUS = 2'b00;
  localparam logic [1:0]    CMD_DATA   = 2'b01;
  localparam logic [1:0]    CMD_WAIT   = 2'b10;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [7:0]    poll_q, poll_d;
  logic [7:0]    sample_q, sample_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          timeout_q, timeout_d;
  logic          en_q, rw_q, rs_q, busy_q, valid_q;
  logic          en_d, rw_d, rs_d, busy_d, valid_d;
  logic [7:0]    poll_inc;

  assign poll_inc = poll_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    cmd_d     = cmd_q;
    poll_d    = poll_q;
    sample_d  = sample_q;
    rd_data_d = rd_data_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (req) begin
          state_d = SETUP;
          cnt_d   = LD_SETUP;
          // cmd 11 is folded into a status read here so RS decoding stays simple
          cmd_d   = (cmd == 2'b11) ? CMD_STATUS : cmd;
          poll_d  = 8'd0;
        end
      end
      SETUP: if (cnt_q == '0) begin
        state_d = EN_HIGH;
        cnt_d   = LD_EN;
      end
      EN_HIGH: if (cnt_q == '0) begin
        sample_d = lcd_data_in;
        state_d  = HOLD;
        cnt_d    = LD_HOLD;
      end
      HOLD: if (cnt_q == '0) begin
        if (cmd_q != CMD_WAIT || !sample_q[7]) begin
          state_d   = DONE;
          rd_data_d = sample_q;
          timeout_d = 1'b0;
        end else begin
          poll_d = poll_inc;
          if (poll_inc == POLL_LIM) begin
            state_d   = DONE;
            rd_data_d = sample_q;
            timeout_d = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = LD_GAP;
          end
        end
      end
      GAP: if (cnt_q == '0) begin
        state_d = SETUP;
        cnt_d   = LD_SETUP;
      end
      default: state_d = IDLE;
    endcase

    // Pad-facing strobes are registered from the next state to keep E glitch-free.
    en_d    = (state_d == EN_HIGH);
    rw_d    = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
    rs_d    = (state_d != IDLE) && (state_d != GAP) && (cmd_d == CMD_DATA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= 2'b00;
      poll_q    <= 8'd0;
      sample_q  <= 8'd0;
      rd_data_q <= 8'd0;
      timeout_q <= 1'b0;
      en_q      <= 1'b0;
      rw_q      <= 1'b0;
      rs_q      <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      poll_q    <= poll_d;
      sample_q  <= sample_d;
      rd_data_q <= rd_data_d;
      timeout_q <= timeout_d;
      en_q      <= en_d;
      rw_q      <= rw_d;
      rs_q      <= rs_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign busy       = busy_q;
  assign rd_valid   = valid_q;
  assign rd_data    = rd_data_q;
  assign rd_timeout = timeout_q;
  assign lcd_en     = en_q;
  assign lcd_rw     = rw_q;
  assign lcd_rs     = rs_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: default instance plus a MAX_POLLS=4 instance for the timeout case.
module tb_lcd_bus_reader;

  logic       clock = 1'b0;
  logic       reset, req, req4;
  logic [1:0] cmd;
  logic [7:0] lcd_data_in;

  logic       busy, vld, to, rs, rw, en;
  logic [7:0] data;
  logic       busy4, vld4, to4, rs4, rw4, en4;
  logic [7:0] data4;

  always #10 clock = ~clock;

  lcd_bus_reader dut (
    .clock(clock), .reset(reset), .req(req), .cmd(cmd),
    .busy(busy), .rd_valid(vld), .rd_data(data), .rd_timeout(to),
    .lcd_data_in(lcd_data_in), .lcd_rs(rs), .lcd_rw(rw), .lcd_en(en)
  );

  lcd_bus_reader #(.MAX_POLLS(4)) dut4 (
    .clock(clock), .reset(reset), .req(req4), .cmd(cmd),
    .busy(busy4), .rd_valid(vld4), .rd_data(data4), .rd_timeout(to4),
    .lcd_data_in(lcd_data_in), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_en(en4)
  );

  int errors = 0;
  int checks = 0;

  // Per-cycle trace; index i holds values just after edge N+i.
  logic       en_t [0:255];
  logic       rw_t [0:255];
  logic       rs_t [0:255];
  logic       busy_t [0:255];
  logic       vld_t [0:255];
  logic       to_t [0:255];
  logic [7:0] data_t [0:255];
  int         rise [0:7];
  int         n_rise, n_vld, first_vld, bad_en;

  int         chg_at, rst_at, rq_a, rq_b;
  logic [7:0] chg_val;
  logic       req_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_sched();
    chg_at = -1; rst_at = -1; rq_a = -1; rq_b = -1; req_hold = 1'b0; chg_val = 8'h00;
  endtask

  task automatic watch(input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (sel) begin
        en_t[i] = en4; rw_t[i] = rw4; rs_t[i] = rs4; busy_t[i] = busy4;
        vld_t[i] = vld4; to_t[i] = to4; data_t[i] = data4;
      end else begin
        en_t[i] = en; rw_t[i] = rw; rs_t[i] = rs; busy_t[i] = busy;
        vld_t[i] = vld; to_t[i] = to; data_t[i] = data;
      end
      if (i == chg_at) lcd_data_in = chg_val;
      if (i == rst_at) reset = 1'b1;
      else if (i == rst_at + 1) reset = 1'b0;
      req  = req_hold || (i == rq_a) || (i == rq_b);
      req4 = 1'b0;
    end
    n_rise = 0; n_vld = 0; first_vld = -1; bad_en = 0;
    for (int k = 0; k < 8; k++) rise[k] = -1;
    for (int i = 0; i < n; i++) begin
      if (en_t[i] && (i == 0 || !en_t[i-1])) begin
        if (n_rise < 8) rise[n_rise] = i;
        n_rise++;
      end
      if (vld_t[i]) begin
        if (first_vld < 0) first_vld = i;
        n_vld++;
      end
      if (en_t[i] && !rw_t[i]) bad_en++;
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; req4 = 1'b0; cmd = 2'b00; lcd_data_in = 8'h00;
    clr_sched();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", vld, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_timeout", to, 1'b0);
    chk("rst_bus", {rs, rw, en}, 3'b000);
    chk("rst_busy4", busy4, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Data read, 0x41
    clr_sched();
    cmd = 2'b01; lcd_data_in = 8'h41; req = 1'b1;
    watch(40, 1'b0);
    chk("t1_rw0", rw_t[0], 1'b1);
    chk("t1_rs0", rs_t[0], 1'b1);
    chk("t1_busy0", busy_t[0], 1'b1);
    chk("t1_en2", en_t[2], 1'b0);
    chk("t1_rise", rise[0], 3);
    chk("t1_en27", en_t[27], 1'b1);
    chk("t1_en28", en_t[28], 1'b0);
    chk("t1_nrise", n_rise, 1);
    chk("t1_rs_hold", rs_t[29], 1'b1);
    chk("t1_data_pre", data_t[29], 8'h00);
    chk("t1_vld_at", first_vld, 30);
    chk("t1_nvld", n_vld, 1);
    chk("t1_data", data_t[30], 8'h41);
    chk("t1_to", to_t[30], 1'b0);
    chk("t1_busy30", busy_t[30], 1'b1);
    chk("t1_busy31", busy_t[31], 1'b0);
    chk("t1_rw31", rw_t[31], 1'b0);
    chk("t1_en_rw", bad_en, 0);

    // Status read, bus changes after the sample
    clr_sched();
    cmd = 2'b00; lcd_data_in = 8'h0A; req = 1'b1;
    chg_at = 28; chg_val = 8'hFF;
    watch(40, 1'b0);
    chk("t2_rs_any", rs_t[0] | rs_t[10] | rs_t[20] | rs_t[29], 1'b0);
    chk("t2_vld_at", first_vld, 30);
    chk("t2_data", data_t[30], 8'h0A);
    chk("t2_data_hold", data_t[39], 8'h0A);

    // Wait-ready: two busy samples then ready
    clr_sched();
    cmd = 2'b10; lcd_data_in = 8'h85; req = 1'b1;
    chg_at = 90; chg_val = 8'h05;
    watch(150, 1'b0);
    chk("t3_nrise", n_rise, 3);
    chk("t3_rise0", rise[0], 3);
    chk("t3_rise1", rise[1], 58);
    chk("t3_rise2", rise[2], 113);
    chk("t3_gap_bus", {rs_t[40], rw_t[40], en_t[40], busy_t[40]}, 4'b0101);
    chk("t3_data_mid", data_t[100], 8'h0A);
    chk("t3_vld_at", first_vld, 140);
    chk("t3_nvld", n_vld, 1);
    chk("t3_data", data_t[140], 8'h05);
    chk("t3_to", to_t[140], 1'b0);
    chk("t3_en_rw", bad_en, 0);

    // Wait-ready timeout on the MAX_POLLS=4 instance
    clr_sched();
    cmd = 2'b10; lcd_data_in = 8'h80; req4 = 1'b1;
    watch(200, 1'b1);
    chk("t4_nrise", n_rise, 4);
    chk("t4_rise3", rise[3], 168);
    chk("t4_vld_at", first_vld, 195);
    chk("t4_nvld", n_vld, 1);
    chk("t4_data", data_t[195], 8'h80);
    chk("t4_to", to_t[195], 1'b1);

    // Reset mid-poll, then a clean read
    clr_sched();
    cmd = 2'b10; lcd_data_in = 8'h05; req = 1'b1;
    rst_at = 9; rq_a = 11;
    watch(50, 1'b0);
    chk("t5_en9", en_t[9], 1'b1);
    chk("t5_data9", data_t[9], 8'h05);
    chk("t5_bus10", {en_t[10], rw_t[10], busy_t[10]}, 3'b000);
    chk("t5_data10", data_t[10], 8'h00);
    chk("t5_nrise", n_rise, 2);
    chk("t5_rise1", rise[1], 15);
    chk("t5_nvld", n_vld, 1);
    chk("t5_vld_at", first_vld, 42);
    chk("t5_data", data_t[42], 8'h05);
    chk("t5_busy43", busy_t[43], 1'b0);

    // req pulses while busy are dropped
    clr_sched();
    cmd = 2'b01; lcd_data_in = 8'h3C; req = 1'b1;
    rq_a = 4; rq_b = 19;
    watch(40, 1'b0);
    chk("t6_nvld", n_vld, 1);
    chk("t6_vld_at", first_vld, 30);
    chk("t6_nrise", n_rise, 1);
    chk("t6_data", data_t[30], 8'h3C);

    // req held high: back-to-back reads
    clr_sched();
    cmd = 2'b00; lcd_data_in = 8'h5A; req = 1'b1; req_hold = 1'b1;
    watch(70, 1'b0);
    chk("t7_rise0", rise[0], 3);
    chk("t7_rise1", rise[1], 34);
    chk("t7_en_gap", en_t[30] | en_t[31] | en_t[33], 1'b0);
    chk("t7_busy31", busy_t[31], 1'b1);
    chk("t7_vld31", vld_t[31], 1'b0);
    chk("t7_nvld", n_vld, 2);
    chk("t7_data", data_t[61], 8'h5A);
    chk("t7_en_rw", bad_en, 0);

    req_hold = 1'b0; req = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    chk("end_idle", {busy, rw, en}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
